// File: rtl/serial_addsub_digit_pkg.sv
// Shared types and default sizing for the digit-serial add/subtract datapath.
//   mode_t          : per-word operation (MODE_ADD / MODE_SUB)
//   DEF_DIGIT_W     : default bits per digit
//   DEF_DIGITS      : default digits per word
package serial_arith_pkg;

  typedef enum logic {MODE_ADD, MODE_SUB} mode_t;

  localparam int unsigned DEF_DIGIT_W = 1;
  localparam int unsigned DEF_DIGITS  = 8;

endpackage

// File: rtl/serial_addsub_digit_if.sv
// Digit-serial operand/result bundle.
//   in_valid, a, b, sub                                    : source -> adder
//   out_valid, out_digit, out_last, out_carry, out_ovf,
//   out_zero                                               : adder -> consumer
// master = digit source / result consumer, slave = serial_addsub_digit.
interface serial_addsub_digit_if #(
  parameter int unsigned DIGIT_W = 1
);

  logic               in_valid;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               sub;
  logic               out_valid;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_last;
  logic               out_carry;
  logic               out_ovf;
  logic               out_zero;

  modport master (
    output in_valid, a, b, sub,
    input  out_valid, out_digit, out_last, out_carry, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, a, b, sub,
    output out_valid, out_digit, out_last, out_carry, out_ovf, out_zero
  );

endinterface

// File: rtl/serial_addsub_digit_fa.sv
// One-bit full adder cell, built from plain logic operators.
//   a, b, cin : addend bits and carry in
//   s, cout   : sum bit and carry out
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial adder/subtractor: one DIGIT_W-bit digit per accepted cycle,
// LSB digit first, DIGITS digits per word, 1-cycle registered latency.
//   clk, rst : clock, synchronous active-high reset
//   bus      : serial_addsub_digit_if.slave (operand digits in, result out)
// Build option: SERIAL_ADDSUB_FLAGS_EN builds the end-of-word carry,
// overflow and zero flags; otherwise those outputs are tied to 0.
module serial_addsub_digit
  import serial_arith_pkg::*;
#(
  parameter int unsigned DIGIT_W = DEF_DIGIT_W,
  parameter int unsigned DIGITS  = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  serial_addsub_digit_if.slave  bus
);

  localparam int unsigned      CNT_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_carry, w_carry_nxt;
  mode_t              r_mode, w_mode_nxt, w_mode;
  logic               r_out_valid;
  logic [DIGIT_W-1:0] r_out_digit;
  logic               r_out_last;

  logic               w_first, w_last, w_cin;
  logic [DIGIT_W-1:0] w_b_eff, w_sum;
  logic [DIGIT_W:0]   w_c;

  // Word start uses the live sub input; mid-word digits use the latched mode.
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST_CNT);
  assign w_mode  = w_first ? (bus.sub ? MODE_SUB : MODE_ADD) : r_mode;
  assign w_cin   = w_first ? bus.sub : r_carry;
  assign w_b_eff = bus.b ^ {DIGIT_W{w_mode == MODE_SUB}};
  assign w_c[0]  = w_cin;

  // Digit ripple.
  for (genvar gi = 0; gi < DIGIT_W; gi++) begin : g_ripple
    full_adder_bit u_fa (
      .a    (bus.a[gi]),
      .b    (w_b_eff[gi]),
      .cin  (w_c[gi]),
      .s    (w_sum[gi]),
      .cout (w_c[gi+1])
    );
  end

  // Word framing state: holds whenever no digit is accepted.
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_carry_nxt = r_carry;
    w_mode_nxt  = r_mode;
    if (bus.in_valid) begin
      w_cnt_nxt   = w_last ? '0 : CNT_W'(r_cnt + 1'b1);
      w_carry_nxt = w_c[DIGIT_W];
      w_mode_nxt  = w_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_mode      <= MODE_ADD;
      r_out_valid <= 1'b0;
      r_out_digit <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_carry     <= w_carry_nxt;
      r_mode      <= w_mode_nxt;
      r_out_valid <= bus.in_valid;
      r_out_digit <= bus.in_valid ? w_sum : '0;
      r_out_last  <= bus.in_valid & w_last;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_digit = r_out_digit;
  assign bus.out_last  = r_out_last;

`ifdef SERIAL_ADDSUB_FLAGS_EN
  logic r_zero_acc;
  logic r_out_carry, r_out_ovf, r_out_zero;
  logic w_zero_word, w_flag_en;

  // Zero accumulator restarts at the first digit of each word.
  assign w_zero_word = (w_first | r_zero_acc) & (w_sum == '0);
  assign w_flag_en   = bus.in_valid & w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero_acc  <= 1'b0;
      r_out_carry <= 1'b0;
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        r_zero_acc <= w_zero_word;
      end
      r_out_carry <= w_flag_en & w_c[DIGIT_W];
      // Signed overflow: carry into the word MSB differs from carry out.
      r_out_ovf   <= w_flag_en & (w_c[DIGIT_W] ^ w_c[DIGIT_W-1]);
      r_out_zero  <= w_flag_en & w_zero_word;
    end
  end

  assign bus.out_carry = r_out_carry;
  assign bus.out_ovf   = r_out_ovf;
  assign bus.out_zero  = r_out_zero;
`else
  assign bus.out_carry = 1'b0;
  assign bus.out_ovf   = 1'b0;
  assign bus.out_zero  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed bench for serial_addsub_digit: a 1-bit x 8 instance and a
// 4-bit x 2 instance sharing clock and reset. Inputs change on the falling
// edge; outputs are sampled on the following falling edge.
module tb_serial_addsub_digit;

`ifdef SERIAL_ADDSUB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  serial_addsub_digit_if #(.DIGIT_W(1)) if8 ();
  serial_addsub_digit_if #(.DIGIT_W(4)) if4 ();

  serial_addsub_digit #(.DIGIT_W(1), .DIGITS(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  serial_addsub_digit #(.DIGIT_W(4), .DIGITS(2)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4.slave)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Flags are expected only when the flag build option is enabled.
  task automatic check_flags(input string tag, input logic c, o, z,
                             input logic ec, eo, ez);
    check({tag, ".carry"}, 8'(c), 8'(FL & ec));
    check({tag, ".ovf"},   8'(o), 8'(FL & eo));
    check({tag, ".zero"},  8'(z), 8'(FL & ez));
  endtask

  task automatic step8(input logic v, ai, bi, si,
                       input logic ev, ed, el, ec, eo, ez, input string tag);
    if8.in_valid = v; if8.a = ai; if8.b = bi; if8.sub = si;
    @(negedge clk);
    check({tag, ".valid"}, 8'(if8.out_valid), 8'(ev));
    if (ev) begin
      check({tag, ".digit"}, 8'(if8.out_digit), 8'(ed));
      check({tag, ".last"},  8'(if8.out_last),  8'(el));
    end
    check_flags(tag, if8.out_carry, if8.out_ovf, if8.out_zero, ec, eo, ez);
  endtask

  task automatic step4(input logic v, input logic [3:0] ai, bi, input logic si,
                       input logic ev, input logic [3:0] ed, input logic el, ec, eo, ez,
                       input string tag);
    if4.in_valid = v; if4.a = ai; if4.b = bi; if4.sub = si;
    @(negedge clk);
    check({tag, ".valid"}, 8'(if4.out_valid), 8'(ev));
    if (ev) begin
      check({tag, ".digit"}, 8'(if4.out_digit), 8'(ed));
      check({tag, ".last"},  8'(if4.out_last),  8'(el));
    end
    check_flags(tag, if4.out_carry, if4.out_ovf, if4.out_zero, ec, eo, ez);
  endtask

  // One 8-bit word; optional stall burst before digit stall_pos and
  // optional inversion of sub on mid-word digits.
  task automatic word8(input logic [7:0] a, b, input logic s, input logic [7:0] res,
                       input logic ec, eo, ez, input int stall_pos, input int stall_n,
                       input logic toggle, input string tag);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_pos) begin
        for (int k = 0; k < stall_n; k++)
          step8(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {tag, ".stall"});
      end
      step8(1'b1, a[i], b[i], (i > 0 && toggle) ? ~s : s,
            1'b1, res[i], i == 7,
            (i == 7) & ec, (i == 7) & eo, (i == 7) & ez,
            $sformatf("%s.d%0d", tag, i));
    end
  endtask

  task automatic word4(input logic [7:0] a, b, input logic s, input logic [7:0] res,
                       input logic ec, eo, ez, input string tag);
    for (int i = 0; i < 2; i++)
      step4(1'b1, a[i*4 +: 4], b[i*4 +: 4], s, 1'b1, res[i*4 +: 4], i == 1,
            (i == 1) & ec, (i == 1) & eo, (i == 1) & ez,
            $sformatf("%s.d%0d", tag, i));
  endtask

  task automatic check_reset8(input string tag);
    check({tag, ".valid"}, 8'(if8.out_valid), 8'h0);
    check({tag, ".digit"}, 8'(if8.out_digit), 8'h0);
    check({tag, ".last"},  8'(if8.out_last),  8'h0);
    check_flags(tag, if8.out_carry, if8.out_ovf, if8.out_zero, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.sub = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.sub = 1'b0;
    repeat (2) @(negedge clk);
    check_reset8("rst8");
    check("rst4.valid", 8'(if4.out_valid), 8'h0);
    check("rst4.digit", 8'(if4.out_digit), 8'h0);
    check("rst4.last",  8'(if4.out_last),  8'h0);
    rst = 1'b0;

    // 1-bit digits, continuous words.
    word8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0, -1, 0, 1'b0, "add5A3C");
    word8(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0, -1, 0, 1'b0, "sub8001");
    word8(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, "sub1020");
    word8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1,
          int'($urandom_range(1, 7)), 3, 1'b1, "addFF01stall");
    step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle8");

    // 4-bit digits, back-to-back words.
    word4(8'hA7, 8'h59, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, "addA759");
    word4(8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0, "sub0305");
    step4(1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, "idle4");

    // Partial word leaving carry set, then reset while in_valid is high.
    step8(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "part.d0");
    step8(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "part.d1");
    step8(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "part.d2");
    rst = 1'b1;
    if8.in_valid = 1'b1; if8.a = 1'b1; if8.b = 1'b1;
    @(negedge clk);
    check_reset8("midrst0");
    @(negedge clk);
    check_reset8("midrst1");
    rst = 1'b0;
    word8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, -1, 0, 1'b0, "add0101");
    step8(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle8b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
